writeback_regfile: RTL and testbench

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

---
 rtl/writeback_regfile.sv | 137 +++++++++++++
 tb/tb_writeback_regfile.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : writeback_regfile
//  Purpose  : Writeback stage of a 5-stage RV32 pipeline. It selects the
//             writeback value, holds the 32 x 32-bit integer register file
//             with two combinational read ports and counts retired
//             instructions.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    INSTRET_W   width of the retired-instruction counter (default 32)
//  Ports
//    clk         in   1          rising-edge clock
//    rst         in   1          asynchronous active-high reset
//    RegWriteW   in   1          writeback register write enable
//    ValidW      in   1          writeback stage holds a real instruction
//    ResultSrcW  in   2          00 ALU, 01 load, 10 PC+4, 11 reserved (0)
//    ALUResultW  in   32         ALU result
//    ReadDataW   in   32         load data
//    PCPlus4W    in   32         link value
//    RdW         in   5          destination register index
//    A1D, A2D    in   5          decode-stage source register indices
//    RD1D, RD2D  out  32         decode-stage source operands
//    ResultW     out  32         selected writeback value
//    InstRetW    out  INSTRET_W  retired-instruction count
//  Configuration macro
//    REGFILE_BYPASS_EN  when defined, a read of the register being written
//                       in the current cycle returns ResultW (write-through).
//                       When undefined, the old value is returned until the
//                       write edge and the hazard unit covers WB-to-D.
// ============================================================================
module writeback_regfile #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RegWriteW,
    input  logic                 ValidW,
    input  logic [1:0]           ResultSrcW,
    input  logic [31:0]          ALUResultW,
    input  logic [31:0]          ReadDataW,
    input  logic [31:0]          PCPlus4W,
    input  logic [4:0]           RdW,
    input  logic [4:0]           A1D,
    input  logic [4:0]           A2D,
    output logic [31:0]          RD1D,
    output logic [31:0]          RD2D,
    output logic [31:0]          ResultW,
    output logic [INSTRET_W-1:0] InstRetW
);

    localparam logic [1:0] c_SRC_ALU  = 2'b00;
    localparam logic [1:0] c_SRC_LOAD = 2'b01;
    localparam logic [1:0] c_SRC_PC4  = 2'b10;

    // x0 is hardwired, so only x1-x31 have storage.
    logic [31:0]          regs_q [1:31];
    logic [31:0]          regs_d [1:31];
    logic [INSTRET_W-1:0] instret_q;
    logic [INSTRET_W-1:0] instret_d;
    logic                 w_write_en;

    // Reserved select returns a defined zero so no X reaches the forwarding net.
    always_comb begin
        ResultW = 32'h0;
        case (ResultSrcW)
            c_SRC_ALU:  ResultW = ALUResultW;
            c_SRC_LOAD: ResultW = ReadDataW;
            c_SRC_PC4:  ResultW = PCPlus4W;
            default:    ResultW = 32'h0;
        endcase
    end

    // Bubbles (ValidW=0) never write, even with a stale RegWriteW.
    assign w_write_en = RegWriteW && ValidW && (RdW != 5'd0) && !rst;

    always_comb begin
        regs_d = regs_q;
        if (w_write_en) begin
            regs_d[RdW] = ResultW;
        end
    end

    always_comb begin
        instret_d = instret_q;
        if (ValidW && !rst) begin
            instret_d = instret_q + INSTRET_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
            instret_q <= '0;
        end else begin
            regs_q    <= regs_d;
            instret_q <= instret_d;
        end
    end

    assign InstRetW = instret_q;

`ifdef REGFILE_BYPASS_EN
    // w_write_en already excludes x0, so a read of x0 never sees ResultW.
    always_comb begin
        RD1D = 32'h0;
        if (A1D != 5'd0) begin
            RD1D = (w_write_en && (A1D == RdW)) ? ResultW : regs_q[A1D];
        end
    end

    always_comb begin
        RD2D = 32'h0;
        if (A2D != 5'd0) begin
            RD2D = (w_write_en && (A2D == RdW)) ? ResultW : regs_q[A2D];
        end
    end
`else
    always_comb begin
        RD1D = 32'h0;
        if (A1D != 5'd0) begin
            RD1D = regs_q[A1D];
        end
    end

    always_comb begin
        RD2D = 32'h0;
        if (A2D != 5'd0) begin
            RD2D = regs_q[A2D];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_writeback_regfile
//  Purpose  : Directed self-checking bench for writeback_regfile. A second,
//             4-bit-counter instance exercises the counter wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_regfile;

    logic        clk;
    logic        rst;
    logic        RegWriteW;
    logic        ValidW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [4:0]  RdW;
    logic [4:0]  A1D;
    logic [4:0]  A2D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] ResultW;
    logic [31:0] InstRetW;

    logic        valid_small;
    logic [31:0] rd1_small;
    logic [31:0] rd2_small;
    logic [31:0] res_small;
    logic [3:0]  ret_small;

    int          n_vec;
    int          n_err;
    logic [31:0] exp_ret;

    writeback_regfile #(.INSTRET_W(32)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteW  (RegWriteW),
        .ValidW     (ValidW),
        .ResultSrcW (ResultSrcW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .RdW        (RdW),
        .A1D        (A1D),
        .A2D        (A2D),
        .RD1D       (RD1D),
        .RD2D       (RD2D),
        .ResultW    (ResultW),
        .InstRetW   (InstRetW)
    );

    writeback_regfile #(.INSTRET_W(4)) u_small (
        .clk        (clk),
        .rst        (rst),
        .RegWriteW  (1'b0),
        .ValidW     (valid_small),
        .ResultSrcW (ResultSrcW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .RdW        (RdW),
        .A1D        (A1D),
        .A2D        (A2D),
        .RD1D       (rd1_small),
        .RD2D       (rd2_small),
        .ResultW    (res_small),
        .InstRetW   (ret_small)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWriteW  = 1'b0;
        ValidW     = 1'b0;
        ResultSrcW = 2'b00;
        ALUResultW = 32'h0;
        ReadDataW  = 32'h0;
        PCPlus4W   = 32'h0;
        RdW        = 5'd0;
        A1D        = 5'd0;
        A2D        = 5'd0;
    endtask

    task automatic wr(input logic [4:0] rd, input logic [31:0] val);
        RegWriteW  = 1'b1;
        ValidW     = 1'b1;
        ResultSrcW = 2'b00;
        ALUResultW = val;
        RdW        = rd;
        step();
        exp_ret = exp_ret + 32'd1;
        idle();
    endtask

    task automatic test_reset();
        idle();
        valid_small = 1'b0;
        rst = 1'b1;
        step();
        step();
        A1D = 5'd1;
        A2D = 5'd31;
        #1;
        n_vec++;
        if (InstRetW !== 32'h0) begin
            n_err++;
            $display("FAIL reset_instret got=%h exp=%h", InstRetW, 32'h0);
        end
        n_vec++;
        if (RD1D !== 32'h0 || RD2D !== 32'h0) begin
            n_err++;
            $display("FAIL reset_reads got=%h/%h exp=0/0", RD1D, RD2D);
        end
        rst = 1'b0;
        exp_ret = 32'h0;
        step();
    endtask

    task automatic test_result_mux();
        logic [31:0] exp_tab [4];
        exp_tab[0] = 32'h11;
        exp_tab[1] = 32'h22;
        exp_tab[2] = 32'h33;
        exp_tab[3] = 32'h0;
        ALUResultW = 32'h11;
        ReadDataW  = 32'h22;
        PCPlus4W   = 32'h33;
        for (int s = 0; s < 4; s++) begin
            ResultSrcW = 2'(s);
            #1;
            n_vec++;
            if (ResultW !== exp_tab[s]) begin
                n_err++;
                $display("FAIL result_mux sel=%0d got=%h exp=%h", s, ResultW, exp_tab[s]);
            end
        end
        idle();
    endtask

    task automatic test_write_x0();
        wr(5'd5, 32'hDEADBEEF);
        wr(5'd0, 32'h12345678);
        A1D = 5'd5;
        A2D = 5'd0;
        #1;
        n_vec++;
        if (RD1D !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL write_x5 got=%h exp=%h", RD1D, 32'hDEADBEEF);
        end
        n_vec++;
        if (RD2D !== 32'h0) begin
            n_err++;
            $display("FAIL x0_protect got=%h exp=%h", RD2D, 32'h0);
        end
        n_vec++;
        if (InstRetW !== exp_ret) begin
            n_err++;
            $display("FAIL instret_count got=%h exp=%h", InstRetW, exp_ret);
        end
        idle();
    endtask

    task automatic test_bubble();
        wr(5'd7, 32'h55);
        RegWriteW  = 1'b1;
        ValidW     = 1'b0;
        RdW        = 5'd7;
        ALUResultW = 32'h1234;
        step();
        idle();
        A1D = 5'd7;
        A2D = 5'd7;
        #1;
        n_vec++;
        if (RD1D !== 32'h55 || RD2D !== 32'h55) begin
            n_err++;
            $display("FAIL bubble_x7 got=%h/%h exp=%h", RD1D, RD2D, 32'h55);
        end
        n_vec++;
        if (InstRetW !== exp_ret) begin
            n_err++;
            $display("FAIL bubble_instret got=%h exp=%h", InstRetW, exp_ret);
        end
        idle();
    endtask

    task automatic test_bypass();
        logic [31:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 32'hCAFE;
`else
        exp_pre = 32'h0;
`endif
        RegWriteW  = 1'b1;
        ValidW     = 1'b1;
        ResultSrcW = 2'b01;
        ReadDataW  = 32'hCAFE;
        RdW        = 5'd9;
        A1D        = 5'd9;
        A2D        = 5'd0;
        #1;
        n_vec++;
        if (RD1D !== exp_pre) begin
            n_err++;
            $display("FAIL bypass_pre got=%h exp=%h", RD1D, exp_pre);
        end
        n_vec++;
        if (RD2D !== 32'h0) begin
            n_err++;
            $display("FAIL bypass_x0 got=%h exp=%h", RD2D, 32'h0);
        end
        step();
        exp_ret = exp_ret + 32'd1;
        RegWriteW = 1'b0;
        ValidW    = 1'b0;
        #1;
        n_vec++;
        if (RD1D !== 32'hCAFE) begin
            n_err++;
            $display("FAIL bypass_post got=%h exp=%h", RD1D, 32'hCAFE);
        end
        // Writing x0 with a matching read index must still read zero.
        RegWriteW  = 1'b1;
        ValidW     = 1'b1;
        RdW        = 5'd0;
        A1D        = 5'd0;
        #1;
        n_vec++;
        if (RD1D !== 32'h0) begin
            n_err++;
            $display("FAIL bypass_x0_wr got=%h exp=%h", RD1D, 32'h0);
        end
        idle();
    endtask

    task automatic test_async_reset();
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'hA5000000 | 32'(i));
        end
        A1D = 5'd1;
        A2D = 5'd31;
        #1;
        n_vec++;
        if (RD1D !== 32'hA5000001 || RD2D !== 32'hA500001F) begin
            n_err++;
            $display("FAIL fill got=%h/%h exp=a5000001/a500001f", RD1D, RD2D);
        end
        // Mid-cycle pulse, checked before any further clock edge.
        #1;
        rst = 1'b1;
        #1;
        n_vec++;
        if (InstRetW !== 32'h0) begin
            n_err++;
            $display("FAIL async_instret got=%h exp=%h", InstRetW, 32'h0);
        end
        for (int i = 1; i < 32; i++) begin
            A1D = 5'(i);
            A2D = 5'(32 - i);
            #0.1;
            n_vec++;
            if (RD1D !== 32'h0 || RD2D !== 32'h0) begin
                n_err++;
                $display("FAIL async_clear x%0d got=%h/%h exp=0", i, RD1D, RD2D);
            end
        end
        // Write and count held off while reset stays asserted, reads stay 0.
        RegWriteW  = 1'b1;
        ValidW     = 1'b1;
        ALUResultW = 32'h99;
        RdW        = 5'd4;
        A1D        = 5'd4;
        #1;
        n_vec++;
        if (RD1D !== 32'h0) begin
            n_err++;
            $display("FAIL rst_read got=%h exp=%h", RD1D, 32'h0);
        end
        step();
        n_vec++;
        if (RD1D !== 32'h0 || InstRetW !== 32'h0) begin
            n_err++;
            $display("FAIL rst_suppress got=%h/%h exp=0/0", RD1D, InstRetW);
        end
        // First edge after release performs the pending write.
        rst = 1'b0;
        ALUResultW = 32'h77;
        RdW        = 5'd3;
        A1D        = 5'd3;
        step();
        exp_ret = 32'd1;
        RegWriteW = 1'b0;
        ValidW    = 1'b0;
        #1;
        n_vec++;
        if (RD1D !== 32'h77 || InstRetW !== exp_ret) begin
            n_err++;
            $display("FAIL post_rst got=%h/%h exp=%h/%h", RD1D, InstRetW, 32'h77, exp_ret);
        end
        idle();
    endtask

    task automatic test_wrap();
        logic [3:0] start;
        start = ret_small;
        valid_small = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (ret_small == 4'hF) break;
            step();
        end
        #1;
        n_vec++;
        if (ret_small !== 4'hF) begin
            n_err++;
            $display("FAIL wrap_full got=%h exp=%h start=%h", ret_small, 4'hF, start);
        end
        step();
        valid_small = 1'b0;
        #1;
        n_vec++;
        if (ret_small !== 4'h0) begin
            n_err++;
            $display("FAIL wrap_zero got=%h exp=%h", ret_small, 4'h0);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        exp_ret = 32'h0;
        rst     = 1'b1;
        valid_small = 1'b0;
        idle();
        test_reset();
        test_result_mux();
        test_write_x0();
        test_bubble();
        test_bypass();
        test_async_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
